// File: rtl/i2s_rx_pkg.sv
// Shared types and constants for the I2S/left-justified audio path.
// Both transmitter and receiver pick up the default word width from here.
package i2s_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SKIP,
      SHIFT,
      WAIT
   } state_t;

   localparam logic        CH_LEFT    = 1'b0;
   localparam int unsigned DATA_W_DEF = 16;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// N-stage synchronizer for an asynchronous clock-like pin.
// Produces single-cycle rise/fall pulses on the synchronized copy.
module sync_edge #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              hist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
         hist  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         hist  <= chain[STAGES-1];
      end
   end

   assign rise = chain[STAGES-1] & ~hist;
   assign fall = ~chain[STAGES-1] & hist;

endmodule

// File: rtl/i2s_rx.sv
// Oversampling I2S / left-justified stereo receiver in the clk32 domain.
// Emits a left/right pair with a one-cycle valid strobe and tracks bclk lock.
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DELAY_BITS  = 0,
   parameter int unsigned SAMPLE_RISE = 0,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic              clk32,
   input  logic              reset_n,
   input  logic              i2s_bclk,
   input  logic              i2s_lrck,
   input  logic              i2s_din,
   output logic [DATA_W-1:0] audio_l,
   output logic [DATA_W-1:0] audio_r,
   output logic              sample_valid,
   output logic              locked,
   output logic              short_err
);

   localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
   localparam int unsigned SKIP_W = $clog2(DELAY_BITS + 2);
   localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

   logic                   bclk_rise;
   logic                   bclk_fall;
   logic [SYNC_STAGES-1:0] lrck_sync;
   logic [SYNC_STAGES-1:0] din_sync;
   logic                   lrck_s;
   logic                   din_s;

   sync_edge #(.STAGES(SYNC_STAGES)) u_bclk_sync (
      .clk  (clk32),
      .rst_n(reset_n),
      .d    (i2s_bclk),
      .rise (bclk_rise),
      .fall (bclk_fall)
   );

   // Same depth as the bclk chain so lrck/din line up with the detected edge.
   always_ff @(posedge clk32 or negedge reset_n) begin
      if (!reset_n) begin
         lrck_sync <= '0;
         din_sync  <= '0;
      end else begin
         lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
         din_sync  <= {din_sync[SYNC_STAGES-2:0], i2s_din};
      end
   end

   assign lrck_s = lrck_sync[SYNC_STAGES-1];
   assign din_s  = din_sync[SYNC_STAGES-1];

   state_t            state;
   logic              ch;
   logic              have_left;
   logic              lrck_prev;
   logic [CNT_W-1:0]  bit_cnt;
   logic [SKIP_W-1:0] skip_cnt;
   logic [DATA_W-1:0] sh;
   logic [DATA_W-1:0] hold;
   logic [TO_W-1:0]   to_cnt;

   logic              evt;
   logic              toggle;
   logic              start;
   logic              timed_out;
   logic [DATA_W-1:0] msb_word;
   logic [DATA_W-1:0] sh_cap;
   logic              commit;
   logic              short_hit;
   logic [DATA_W-1:0] commit_word;

   assign evt       = (SAMPLE_RISE != 0) ? bclk_rise : bclk_fall;
   assign toggle    = evt && (lrck_s != lrck_prev);
   assign start     = toggle && ((state != IDLE) || (lrck_s == CH_LEFT));
   assign timed_out = (to_cnt == TO_W'(TIMEOUT));

   // The shift register stays left-aligned: each bit lands at its final
   // position, so a truncated slot is already zero-padded in the LSBs.
   assign msb_word = {din_s, {(DATA_W-1){1'b0}}};
   assign sh_cap   = sh | (msb_word >> bit_cnt);

   always_comb begin
      commit      = 1'b0;
      short_hit   = 1'b0;
      commit_word = sh_cap;
      if (evt && (state == SHIFT)) begin
         if (toggle) begin
            commit      = 1'b1;
            short_hit   = 1'b1;
            commit_word = sh;
         end else if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            commit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk32 or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         ch           <= CH_LEFT;
         have_left    <= 1'b0;
         lrck_prev    <= 1'b0;
         bit_cnt      <= '0;
         skip_cnt     <= '0;
         sh           <= '0;
         hold         <= '0;
         to_cnt       <= '0;
         audio_l      <= '0;
         audio_r      <= '0;
         sample_valid <= 1'b0;
         locked       <= 1'b0;
         short_err    <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         short_err    <= 1'b0;

         if (evt) begin
            to_cnt <= '0;
         end else if (!timed_out) begin
            to_cnt <= to_cnt + 1'b1;
         end

         if (evt) begin
            lrck_prev <= lrck_s;
            short_err <= short_hit;

            if (commit) begin
               if (ch == CH_LEFT) begin
                  hold      <= commit_word;
                  have_left <= 1'b1;
               end else begin
                  if (have_left) begin
                     audio_l      <= hold;
                     audio_r      <= commit_word;
                     sample_valid <= 1'b1;
                     locked       <= 1'b1;
                  end
                  have_left <= 1'b0;
               end
            end

            if (start) begin
               ch <= lrck_s;
               if (DELAY_BITS > 0) begin
                  // The toggle event itself is the first delay bit.
                  state    <= SKIP;
                  skip_cnt <= SKIP_W'(1);
                  sh       <= '0;
                  bit_cnt  <= '0;
               end else begin
                  state   <= SHIFT;
                  sh      <= msb_word;
                  bit_cnt <= CNT_W'(1);
               end
            end else begin
               unique case (state)
                  SKIP: begin
                     if (skip_cnt == SKIP_W'(DELAY_BITS)) begin
                        state   <= SHIFT;
                        sh      <= msb_word;
                        bit_cnt <= CNT_W'(1);
                     end else begin
                        skip_cnt <= skip_cnt + 1'b1;
                     end
                  end
                  SHIFT: begin
                     sh      <= sh_cap;
                     bit_cnt <= bit_cnt + 1'b1;
                     if (commit) begin
                        state <= WAIT;
                     end
                  end
                  default: ;
               endcase
            end
         end else if (timed_out) begin
            locked    <= 1'b0;
            state     <= IDLE;
            have_left <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: a left-justified instance and a Philips instance,
// each fed by a slot-level transmitter model with randomized words.
module tb_i2s_rx;

   localparam int unsigned DW = 16;
   localparam int          BH = 100;   // bclk half period = 10 clk32 cycles

   logic clk32   = 1'b0;
   logic reset_n = 1'b0;
   logic bclk_a = 1'b0, lrck_a = 1'b0, din_a = 1'b0;
   logic bclk_b = 1'b0, lrck_b = 1'b0, din_b = 1'b0;
   logic [DW-1:0] l_a, r_a, l_b, r_b;
   logic v_a, lk_a, se_a, v_b, lk_b, se_b;

   i2s_rx #(.DATA_W(DW), .SYNC_STAGES(2), .DELAY_BITS(0), .SAMPLE_RISE(0), .TIMEOUT(255)) dut_a (
      .clk32(clk32), .reset_n(reset_n), .i2s_bclk(bclk_a), .i2s_lrck(lrck_a), .i2s_din(din_a),
      .audio_l(l_a), .audio_r(r_a), .sample_valid(v_a), .locked(lk_a), .short_err(se_a));

   i2s_rx #(.DATA_W(DW), .SYNC_STAGES(2), .DELAY_BITS(1), .SAMPLE_RISE(1), .TIMEOUT(255)) dut_b (
      .clk32(clk32), .reset_n(reset_n), .i2s_bclk(bclk_b), .i2s_lrck(lrck_b), .i2s_din(din_b),
      .audio_l(l_b), .audio_r(r_b), .sample_valid(v_b), .locked(lk_b), .short_err(se_b));

   always #5 clk32 = ~clk32;

   typedef struct {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
   } pair_t;

   pair_t qa[$];
   pair_t qb[$];
   pair_t pa, pb;

   int tests = 0;
   int fails = 0;

   bit            started[2];
   bit            have[2];
   logic          prev_lr[2];
   logic [DW-1:0] held[2];
   logic [DW-1:0] last_l[2];
   logic [DW-1:0] last_r[2];
   int            exp_short[2];
   int            got_short[2];
   logic          carry_b = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Slot-level model: a left slot begins a pair once the stream has seen a
   // right->left change; a right slot completes it if a left word is held.
   task automatic model_slot(input int m, input logic lr, input logic [DW-1:0] word, input int nbits);
      logic [DW-1:0] wc;
      pair_t p;
      if (lr != prev_lr[m] && lr == 1'b0) started[m] = 1'b1;
      prev_lr[m] = lr;
      if (started[m]) begin
         wc = (nbits >= int'(DW)) ? word : (word & ~({DW{1'b1}} >> nbits));
         if (nbits < int'(DW)) exp_short[m]++;
         if (lr == 1'b0) begin
            held[m] = wc;
            have[m] = 1'b1;
         end else if (have[m]) begin
            p.l = held[m];
            p.r = wc;
            if (m == 0) qa.push_back(p); else qb.push_back(p);
            last_l[m] = p.l;
            last_r[m] = p.r;
            have[m]   = 1'b0;
         end
      end
   endtask

   task automatic model_reset(input int m, input logic lr);
      started[m] = 1'b0;
      have[m]    = 1'b0;
      prev_lr[m] = lr;
      last_l[m]  = '0;
      last_r[m]  = '0;
      if (m == 0) qa.delete(); else qb.delete();
   endtask

   task automatic model_timeout(input int m);
      started[m] = 1'b0;
      have[m]    = 1'b0;
   endtask

   // Mode 0: data changes on bclk rise, lrck aligned with MSB.
   // Mode 1: data changes on bclk fall, data lags lrck by one bit.
   task automatic send_slot(input int m, input logic lr, input logic [DW-1:0] word,
                            input int nbits, input int slot_w);
      logic b;
      model_slot(m, lr, word, nbits);
      for (int i = 0; i < slot_w; i++) begin
         b = (i < nbits) ? word[DW-1-i] : 1'($urandom);
         if (m == 0) begin
            bclk_a = 1'b1; lrck_a = lr; din_a = b;
            #BH;
            bclk_a = 1'b0;
            #BH;
         end else begin
            bclk_b = 1'b0; lrck_b = lr; din_b = carry_b;
            #BH;
            bclk_b = 1'b1;
            #BH;
            carry_b = b;
         end
      end
   endtask

   task automatic send_frame(input int m, input logic [DW-1:0] l, input logic [DW-1:0] r, input int slot_w);
      send_slot(m, 1'b0, l, DW, slot_w);
      send_slot(m, 1'b1, r, DW, slot_w);
   endtask

   task automatic drain();
      repeat (40) @(negedge clk32);
   endtask

   always @(negedge clk32) begin
      if (reset_n) begin
         if (se_a) got_short[0]++;
         if (v_a) begin
            if (qa.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_valid_a: got pulse l=0x%0h r=0x%0h, expected none", l_a, r_a);
            end else begin
               pa = qa.pop_front();
               check("audio_l_a", 32'(l_a), 32'(pa.l));
               check("audio_r_a", 32'(r_a), 32'(pa.r));
               check("locked_a", 32'(lk_a), 32'd1);
            end
         end
      end
   end

   always @(negedge clk32) begin
      if (reset_n) begin
         if (se_b) got_short[1]++;
         if (v_b) begin
            if (qb.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_valid_b: got pulse l=0x%0h r=0x%0h, expected none", l_b, r_b);
            end else begin
               pb = qb.pop_front();
               check("audio_l_b", 32'(l_b), 32'(pb.l));
               check("audio_r_b", 32'(r_b), 32'(pb.r));
               check("locked_b", 32'(lk_b), 32'd1);
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int m = 0; m < 2; m++) begin
         model_reset(m, 1'b0);
         exp_short[m] = 0;
         got_short[m] = 0;
      end
      reset_n = 1'b0;
      repeat (10) @(negedge clk32);
      check("rst_audio_l", 32'(l_a), 32'd0);
      check("rst_audio_r", 32'(r_a), 32'd0);
      check("rst_valid", 32'(v_a), 32'd0);
      check("rst_locked", 32'(lk_a), 32'd0);
      check("rst_short", 32'(se_a), 32'd0);
      check("rst_locked_b", 32'(lk_b), 32'd0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk32);

      // Left-justified loopback: warm-up frame, fixed frame, random frames
      send_frame(0, 16'($urandom), 16'($urandom), DW);
      send_frame(0, 16'hA55A, 16'h1234, DW);
      for (int k = 0; k < 4; k++) send_frame(0, 16'($urandom), 16'($urandom), DW);
      drain();
      check("pending_a_loop", 32'(qa.size()), 32'd0);

      // Short right slot of 12 bits
      send_slot(0, 1'b0, 16'($urandom), DW, DW);
      send_slot(0, 1'b1, 16'hACF0, 12, 12);
      send_frame(0, 16'($urandom), 16'($urandom), DW);
      drain();
      check("pending_a_short", 32'(qa.size()), 32'd0);
      check("short_count_a", 32'(got_short[0]), 32'(exp_short[0]));

      // bclk stop: lock held before timeout, dropped after, outputs frozen
      send_frame(0, 16'($urandom), 16'($urandom), DW);
      repeat (200) @(negedge clk32);
      check("locked_before_timeout", 32'(lk_a), 32'd1);
      repeat (100) @(negedge clk32);
      check("locked_after_timeout", 32'(lk_a), 32'd0);
      check("hold_audio_l", 32'(l_a), 32'(last_l[0]));
      check("hold_audio_r", 32'(r_a), 32'(last_r[0]));
      model_timeout(0);
      send_frame(0, 16'($urandom), 16'($urandom), DW);
      drain();
      check("pending_a_recover", 32'(qa.size()), 32'd0);
      check("locked_recovered", 32'(lk_a), 32'd1);

      // Reset released in the middle of a right slot
      reset_n = 1'b0;
      model_reset(0, lrck_a);
      model_reset(1, lrck_b);
      fork
         begin
            send_slot(0, 1'b1, 16'($urandom), DW, DW);
            send_frame(0, 16'($urandom), 16'($urandom), DW);
            send_frame(0, 16'($urandom), 16'($urandom), DW);
         end
         begin
            #(BH * 2 * 5 + 30);
            reset_n = 1'b1;
         end
      join
      drain();
      check("pending_a_midframe", 32'(qa.size()), 32'd0);

      // Reset asserted while shifting a left word
      fork
         begin
            for (int k = 0; k < 3; k++) send_frame(0, 16'($urandom), 16'($urandom), DW);
         end
         begin
            #(BH * 2 * 6 + 30);
            reset_n = 1'b0;
            #1;
            check("async_rst_audio_l", 32'(l_a), 32'd0);
            check("async_rst_audio_r", 32'(r_a), 32'd0);
            check("async_rst_valid", 32'(v_a), 32'd0);
            check("async_rst_locked", 32'(lk_a), 32'd0);
            check("async_rst_short", 32'(se_a), 32'd0);
            #50;
            model_reset(0, lrck_a);
            model_reset(1, lrck_b);
            reset_n = 1'b1;
         end
      join
      drain();
      check("pending_a_reset", 32'(qa.size()), 32'd0);
      check("short_count_a_final", 32'(got_short[0]), 32'(exp_short[0]));

      // Philips format on the second instance, 32-bit slots
      send_frame(1, 16'($urandom), 16'($urandom), 32);
      send_frame(1, 16'h8001, 16'h7FFE, 32);
      for (int k = 0; k < 3; k++) send_frame(1, 16'($urandom), 16'($urandom), 32);
      drain();
      check("pending_b", 32'(qb.size()), 32'd0);
      check("short_count_b", 32'(got_short[1]), 32'(exp_short[1]));
      check("locked_b_final", 32'(lk_b), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S/left-justified audio receiver: recovers stereo 16-bit PCM from an external bclk/lrck/din source, such as an ADC or a second board driving our own I2S format.
- All three pins are asynchronous to the system clock. The block oversamples them in the clk32 domain.
- Output is a left/right sample pair with a single-cycle valid strobe, suitable for mixing into the misterynano audio path.
- Includes loss-of-clock detection so downstream logic can ignore stale data.

Parameters:
- DATA_W, 16: bits captured per channel, MSB first.
- SYNC_STAGES, 2: synchronizer flops per input pin (minimum 2).
- DELAY_BITS, 0: bclk periods between an lrck transition and the MSB. 0 = left-justified (our transmitter), 1 = Philips I2S.
- SAMPLE_RISE, 0: 0 = sample din on the bclk falling edge (our transmitter changes din on the rising edge); 1 = sample on the rising edge.
- TIMEOUT, 255: clk32 cycles without a sample edge before `locked` drops.

Ports:
- clk32, input, 1: system clock, 32 MHz.
- reset_n, input, 1: asynchronous, active-low reset.
- i2s_bclk, input, 1: bit clock, asynchronous.
- i2s_lrck, input, 1: word select; 0 = left, 1 = right. Asynchronous.
- i2s_din, input, 1: serial data, asynchronous.
- audio_l, output, DATA_W: last complete left sample.
- audio_r, output, DATA_W: last complete right sample.
- sample_valid, output, 1: one-cycle pulse when audio_l/audio_r update.
- locked, output, 1: bclk is present and a full frame has been received.
- short_err, output, 1: one-cycle pulse when a slot ends before DATA_W bits were captured.

Behaviour:
- Reset (async assert, sync release): all synchronizers, counters and outputs go to 0, and the FSM goes to IDLE.
- Synchronize each pin through SYNC_STAGES flops, plus one history flop on bclk and on lrck.
- Sample event: the selected bclk edge, detected on the synchronized copy. din and lrck are taken from the same synchronized stage as bclk so that all three stay aligned.
- All actions below happen only on sample-event cycles, except the timeout counter.
- lrck toggle: lrck at the current sample event differs from lrck at the previous sample event.
- FSM states:
  - IDLE: wait for an lrck toggle 1->0 (start of left slot). On that toggle, clear bit_cnt and the shift register, then go to SKIP if DELAY_BITS > 0, else go to SHIFT and capture the current din as the MSB.
  - SKIP: count DELAY_BITS sample events, then go to SHIFT.
  - SHIFT: shift din in MSB first. When DATA_W bits are captured, commit the word (below) and go to WAIT.
  - WAIT: ignore extra slot bits (slot width is arbitrary, e.g. 16 or 32).
- Any lrck toggle while in SKIP, SHIFT or WAIT restarts the channel: select channel = new lrck and re-enter SKIP/SHIFT exactly as from IDLE.
- Toggle during SHIFT with fewer than DATA_W bits captured:
  - Left-align the partial word and pad the LSBs with 0.
  - Commit it and pulse short_err.
  - The new slot's first bit is still captured in that same cycle.
- Commit rules:
  - Left word goes to an internal hold register and sets have_left.
  - Right word: if have_left, then on the next cycle audio_l <= hold, audio_r <= word, sample_valid = 1, have_left cleared, locked = 1. If have_left = 0 (startup or resync), discard the word with no pulse.
- Latency:
  - Pin edge to sample event: SYNC_STAGES + 1 clk32 cycles.
  - sample_valid asserts 1 cycle after the sample event of the right-channel bit DATA_W-1.
  - audio_l/audio_r hold their value until the next pulse.
- Timeout:
  - A counter is cleared on each sample event and saturates at TIMEOUT.
  - On reaching TIMEOUT: locked <= 0, FSM -> IDLE, have_left cleared.
  - Outputs keep their last values.
- din toggling without any bclk edge has no effect.
- Minimum bclk half-period: SYNC_STAGES + 2 clk32 cycles. Faster input is unsupported; no detection is required.

Decomposition:
- Package i2s_pkg:
  - state enum {IDLE, SKIP, SHIFT, WAIT}.
  - Constant CH_LEFT = 0.
  - Shared DATA_W default, so the transmitter and receiver agree.
- One sub-module, `sync_edge`: an N-stage synchronizer with rise/fall pulse outputs, instantiated for bclk. lrck and din use plain sync chains of identical depth.

Test Plan:
- Loopback format (bclk period 20 clk32 cycles, 16-bit slots, DELAY_BITS=0, SAMPLE_RISE=0): send L=16'hA55A, R=16'h1234 after one warm-up frame -> one sample_valid with audio_l=A55A, audio_r=1234, locked=1; no pulse during the warm-up frame's right slot.
- Philips mode (DELAY_BITS=1, SAMPLE_RISE=1), 32-bit slots with L=16'h8001, R=16'h7FFE, extra 16 slot bits random -> outputs 8001/7FFE; random bits ignored; exactly one pulse per frame.
- Short slot: right slot only 12 bits long with bits 1010_1100_1111, then lrck toggles -> short_err pulse, audio_r=16'hACF0, next left captured correctly.
- Start mid-frame (reset released during a right slot) -> no sample_valid until the first full left+right pair.
- Stop bclk for 300 cycles -> locked falls after 255 idle cycles; audio_l/audio_r unchanged; recovery after one full frame.
- Assert reset_n low mid-SHIFT -> all outputs 0 immediately (asynchronously); after release, behaviour matches the mid-frame start case.
